// File: rtl/i2s_audio_tx.sv
// I2S serialiser for the external stereo DAC: one free-running 9-bit divider produces MCLK/SCLK/LRCLK/SDIN.
// Optional macro I2S_LEFT_JUSTIFIED_EN selects left-justified framing (MSB coincident with the LRCLK edge).
module i2s_audio_tx #(
  parameter int SAMPLE_BITS = 16
) (
  input  logic        sysclk,
  input  logic        rst_n,
  input  logic [15:0] left_i,
  input  logic [15:0] right_i,
  input  logic        mute_i,
  output logic        sample_strobe,
  output logic        mclk,
  output logic        sclk,
  output logic        lrclk,
  output logic        sdin
);

`ifdef I2S_LEFT_JUSTIFIED_EN
  // Capture one cycle ahead so the shadow is ready for the slot-0 MSB load.
  localparam logic [8:0] CAPTURE_CNT = 9'd511;
`else
  localparam logic [8:0] CAPTURE_CNT = 9'd0;
`endif

  logic [8:0]             cnt;
  logic [8:0]             cnt_next;
  logic [4:0]             slot_next;
  logic                   ch_next;
  logic [SAMPLE_BITS-1:0] shadow_l;
  logic [SAMPLE_BITS-1:0] shadow_r;
  logic [SAMPLE_BITS-1:0] shadow_sel;
  logic                   next_bit;

  assign cnt_next  = cnt + 9'd1;
  assign slot_next = cnt_next[7:3];
  assign ch_next   = cnt_next[8];

  assign mclk  = cnt[0];
  assign sclk  = cnt[2];
  assign lrclk = cnt[8];

  // Bit that goes out in the slot starting at the next SCLK falling edge.
  always_comb begin
    next_bit   = 1'b0;
    shadow_sel = ch_next ? shadow_r : shadow_l;
    for (int i = 0; i < SAMPLE_BITS; i++) begin
`ifdef I2S_LEFT_JUSTIFIED_EN
      if (int'(slot_next) == SAMPLE_BITS - 1 - i) next_bit = shadow_sel[i];
`else
      if (int'(slot_next) == SAMPLE_BITS - i) next_bit = shadow_sel[i];
`endif
    end
  end

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      cnt           <= '0;
      shadow_l      <= '0;
      shadow_r      <= '0;
      sdin          <= 1'b0;
      sample_strobe <= 1'b0;
    end else begin
      cnt           <= cnt_next;
      sample_strobe <= (cnt_next == CAPTURE_CNT);
      if (cnt_next[2:0] == 3'd0) sdin <= next_bit;
      // Only the top SAMPLE_BITS of each MSB-aligned input are kept.
      if (cnt_next == CAPTURE_CNT) begin
        shadow_l <= mute_i ? '0 : left_i[15 -: SAMPLE_BITS];
        shadow_r <= mute_i ? '0 : right_i[15 -: SAMPLE_BITS];
      end
    end
  end

endmodule

// File: tb/tb_i2s_audio_tx.sv
// Self-checking bench for i2s_audio_tx: random samples, scoreboard of expected 32-slot half-frame words.
// Honours I2S_LEFT_JUSTIFIED_EN the same way as the design.
module tb_i2s_audio_tx;

  localparam int SB = 16;
`ifdef I2S_LEFT_JUSTIFIED_EN
  localparam int CAP   = 511;
  localparam int DELAY = 0;
`else
  localparam int CAP   = 0;
  localparam int DELAY = 1;
`endif

  logic        sysclk;
  logic        rst_n;
  logic [15:0] left_i;
  logic [15:0] right_i;
  logic        mute_i;
  logic        sample_strobe;
  logic        mclk;
  logic        sclk;
  logic        lrclk;
  logic        sdin;

  i2s_audio_tx #(.SAMPLE_BITS(SB)) dut (
    .sysclk        (sysclk),
    .rst_n         (rst_n),
    .left_i        (left_i),
    .right_i       (right_i),
    .mute_i        (mute_i),
    .sample_strobe (sample_strobe),
    .mclk          (mclk),
    .sclk          (sclk),
    .lrclk         (lrclk),
    .sdin          (sdin)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  int          total = 0;
  int          bad = 0;
  int          phase = 0;
  bit          started = 0;
  bit          rst_flag = 0;
  logic        prev_sdin = 1'b0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Half-frame as seen on the wire: bit 31 is slot 0; sample MSB-first, then zeros.
  function automatic logic [31:0] frame_word(input logic [15:0] v);
    logic [15:0] mask;
    logic [31:0] w;
    mask = ~(16'hFFFF >> SB);
    w = {v & mask, 16'h0000};
    return w >> DELAY;
  endfunction

  // Reference model: frame position, expected clocks/strobe, and words queued at capture.
  always @(posedge sysclk) begin
    if (!rst_n) begin
      phase    = 0;
      rst_flag = 1;
      started  = 1;
      exp_q.delete();
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h0);
    end else if (started) begin
      phase    = (phase + 1) % 512;
      rst_flag = 0;
      if (phase == CAP) begin
        exp_q.push_back(mute_i ? 32'h0 : frame_word(left_i));
        exp_q.push_back(mute_i ? 32'h0 : frame_word(right_i));
      end
    end
    #1;
    if (started) begin
      check("mclk", {31'b0, mclk}, 32'(phase & 1));
      check("sclk", {31'b0, sclk}, 32'((phase >> 2) & 1));
      check("lrclk", {31'b0, lrclk}, 32'((phase >> 8) & 1));
      check("strobe", {31'b0, sample_strobe}, {31'b0, (!rst_flag && phase == CAP)});
      if (rst_flag) check("sdin_reset", {31'b0, sdin}, 32'h0);
      else if (phase % 8 != 0) check("sdin_hold", {31'b0, sdin}, {31'b0, prev_sdin});
      prev_sdin = sdin;
    end
  end

  // Monitor: acts like the DAC, sampling sdin on SCLK rising edges and scoring full half-frames.
  logic [31:0] mon_word = 32'h0;
  int          mon_bits = 0;
  int          mon_idx = 0;
  logic        prev_sclk = 1'b0;
  always @(posedge sysclk) begin
    logic in_rst;
    logic [31:0] exp;
    in_rst = !rst_n;
    #1;
    if (in_rst) begin
      mon_bits  = 0;
      mon_idx   = 0;
      prev_sclk = 1'b0;
    end else if (started) begin
      if (sclk && !prev_sclk) begin
        mon_word = {mon_word[30:0], sdin};
        mon_bits++;
        if (mon_bits == 32) begin
          mon_bits = 0;
          check("word_channel", {31'b0, lrclk}, 32'(mon_idx % 2));
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL word_underflow: got %h expected none queued", mon_word);
          end else begin
            exp = exp_q.pop_front();
            check(lrclk ? "word_right" : "word_left", mon_word, exp);
          end
          mon_idx++;
        end
      end
      prev_sclk = sclk;
    end
  end

  task automatic run_cycles(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  task automatic wait_phase(input int p);
    int n = 0;
    while (phase != p && n < 1024) begin
      @(negedge sysclk);
      n++;
    end
    check("wait_phase", 32'(phase), 32'(p));
  endtask

  initial begin
    rst_n   = 1'b0;
    left_i  = 16'h8001;
    right_i = 16'h7FFE;
    mute_i  = 1'b0;
    run_cycles(3);
    rst_n = 1'b1;
    $display("[TB] fixed pattern 8001/7FFE");
    run_cycles(1700);

    $display("[TB] random samples changing every cycle");
    repeat (3000) begin
      @(negedge sysclk);
      left_i  = 16'($urandom);
      right_i = 16'($urandom);
      mute_i  = ($urandom_range(0, 15) == 0);
    end

    $display("[TB] mute on a single capture");
    mute_i  = 1'b0;
    left_i  = 16'hFFFF;
    right_i = 16'($urandom);
    wait_phase((CAP + 511) % 512);
    mute_i = 1'b1;
    @(negedge sysclk);
    mute_i = 1'b0;
    run_cycles(1200);

    $display("[TB] mid-frame reset");
    wait_phase(300);
    rst_n = 1'b0;
    @(negedge sysclk);
    rst_n   = 1'b1;
    left_i  = 16'hA5A5;
    right_i = 16'h5A5A;
    run_cycles(1300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
